psl_command_responder: RTL and testbench

// - PSL-side responder for the AFU command/buffer/response interface; the opposite end of the AFU command path.
// - Accepts AFU cache-line commands, moves data through the buffer read/write ports against an internal line memory, and returns tagged responses with credits.
// - Used as the loopback/emulation target for the AFU command path in simulation and standalone FPGA bring-up.

---
 rtl/psl_command_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_psl_command_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psl_command_responder.sv
// PSL-side responder: queues AFU commands, moves cache lines through the buffer
// ports against a local line memory and returns one tagged response per command.
module psl_command_responder #(
    parameter int CREDITS   = 8,
    parameter int MEM_LINES = 256,
    parameter int BRLAT     = 1
) (
    input  logic         clock,
    input  logic         rstn_in,
    input  logic         ah_cvalid,
    input  logic [7:0]   ah_ctag,
    input  logic [12:0]  ah_com,
    input  logic [63:0]  ah_cea,
    input  logic [11:0]  ah_csize,
    output logic [7:0]   ha_croom,
    output logic         ha_brvalid,
    output logic [7:0]   ha_brtag,
    output logic [5:0]   ha_brad,
    input  logic [511:0] ah_brdata,
    output logic         ha_bwvalid,
    output logic [7:0]   ha_bwtag,
    output logic [5:0]   ha_bwad,
    output logic [511:0] ha_bwdata,
    output logic         ha_rvalid,
    output logic [7:0]   ha_rtag,
    output logic [7:0]   ha_response,
    output logic [8:0]   ha_rcredits,
    output logic         cmd_overflow
);

    localparam int LW   = $clog2(MEM_LINES);
    localparam int PW   = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int CNTW = $clog2(CREDITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_BW0, S_BW1, S_BR0, S_BR1, S_WAIT, S_RESP
    } state_t;

    // Only the line part of the address is kept; the byte offset never matters.
    typedef struct packed {
        logic [7:0]  tag;
        logic [12:0] com;
        logic [56:0] line_addr;
        logic [11:0] csize;
    } cmd_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    cmd_t              cur_q, cur_d;
    logic [7:0]        resp_q, resp_d;
    logic [LW-1:0]     line_q, line_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic [511:0]      half0_q, half0_d;
    logic [BRLAT-1:0]  pend_v_q, pend_v_d, pend_ad_q, pend_ad_d;

    cmd_t              fifo_mem [CREDITS];
    logic [1023:0]     line_mem [MEM_LINES];
    logic [1023:0]     mem_rd;

    logic fifo_full, push_ok, pop, mem_we;
    logic is_read, is_write, is_restart, range_bad, size_bad;
    logic cea_offset_unused;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cea_offset_unused = ^ah_cea[6:0];
    assign fifo_full  = (count_q == CNTW'(CREDITS));
    assign mem_rd     = line_mem[line_q];
    assign is_read    = (cur_q.com == 13'h0A00) || (cur_q.com == 13'h0A50);
    assign is_write   = (cur_q.com == 13'h0D00) || (cur_q.com == 13'h0D60);
    assign is_restart = (cur_q.com == 13'h0001);
    assign range_bad  = |cur_q.line_addr[56:LW];
    assign size_bad   = (cur_q.csize == 12'd0) || (cur_q.csize > 12'd128);
    assign ha_croom   = 8'(CREDITS);
    assign cmd_overflow = overflow_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        cur_d       = cur_q;
        resp_d      = resp_q;
        line_d      = line_q;
        wait_cnt_d  = wait_cnt_q;
        pop         = 1'b0;
        ha_brvalid  = 1'b0;
        ha_brtag    = 8'h00;
        ha_brad     = 6'd0;
        ha_bwvalid  = 1'b0;
        ha_bwtag    = 8'h00;
        ha_bwad     = 6'd0;
        ha_bwdata   = '0;
        ha_rvalid   = 1'b0;
        ha_rtag     = 8'h00;
        ha_response = 8'h00;
        ha_rcredits = 9'd0;

        push_ok = ah_cvalid && !fifo_full;
        if (ah_cvalid && fifo_full) overflow_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cur_d   = fifo_mem[rd_ptr_q];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                line_d  = cur_q.line_addr[LW-1:0];
                resp_d  = 8'h00;
                state_d = S_RESP;
                if (!(is_read || is_write || is_restart)) begin
                    resp_d = 8'h08;
                end else if (!is_restart && (range_bad || size_bad)) begin
                    resp_d = 8'h01;
                end else if (is_read) begin
                    state_d = S_BW0;
                end else if (is_write) begin
                    state_d = S_BR0;
                end
            end
            S_BW0: begin
                ha_bwvalid = 1'b1;
                ha_bwtag   = cur_q.tag;
                ha_bwdata  = mem_rd[511:0];
                state_d    = S_BW1;
            end
            S_BW1: begin
                ha_bwvalid = 1'b1;
                ha_bwtag   = cur_q.tag;
                ha_bwad    = 6'd1;
                ha_bwdata  = mem_rd[1023:512];
                state_d    = S_RESP;
            end
            S_BR0: begin
                ha_brvalid = 1'b1;
                ha_brtag   = cur_q.tag;
                state_d    = S_BR1;
            end
            S_BR1: begin
                ha_brvalid = 1'b1;
                ha_brtag   = cur_q.tag;
                ha_brad    = 6'd1;
                // RESP lines up with the cycle the second half arrives.
                if (BRLAT == 1) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = 2'(BRLAT - 1);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 2'd1;
                if (wait_cnt_q == 2'd1) state_d = S_RESP;
            end
            S_RESP: begin
                ha_rvalid   = 1'b1;
                ha_rtag     = cur_q.tag;
                ha_response = resp_q;
                ha_rcredits = 9'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);
        if (pop)     rd_ptr_d = ptr_next(rd_ptr_q);
        count_d = count_q + CNTW'(push_ok) - CNTW'(pop);
    end

    // Buffer-read requests travel down a BRLAT-deep pipe to mark when data lands.
    always_comb begin
        pend_v_d     = '0;
        pend_ad_d    = '0;
        pend_v_d[0]  = ha_brvalid;
        pend_ad_d[0] = ha_brad[0];
        for (int i = 1; i < BRLAT; i++) begin
            pend_v_d[i]  = pend_v_q[i-1];
            pend_ad_d[i] = pend_ad_q[i-1];
        end
        half0_d = half0_q;
        mem_we  = 1'b0;
        if (pend_v_q[BRLAT-1]) begin
            if (pend_ad_q[BRLAT-1]) mem_we  = 1'b1;
            else                    half0_d = ah_brdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!rstn_in) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            pend_v_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pend_v_q   <= pend_v_d;
        end
    end

    always_ff @(posedge clock) begin
        cur_q      <= cur_d;
        resp_q     <= resp_d;
        line_q     <= line_d;
        wait_cnt_q <= wait_cnt_d;
        half0_q    <= half0_d;
        pend_ad_q  <= pend_ad_d;
    end

    always_ff @(posedge clock) begin
        if (rstn_in && push_ok)
            fifo_mem[wr_ptr_q] <= '{tag: ah_ctag, com: ah_com,
                                    line_addr: ah_cea[63:7], csize: ah_csize};
        if (rstn_in && mem_we)
            line_mem[line_q] <= {ah_brdata, half0_q};
    end

endmodule

// File: tb/tb_psl_command_responder.sv
// Directed bench for psl_command_responder: line write/read loopback, error
// responses, FIFO overflow ordering and reset in the middle of a write.
module tb_psl_command_responder;

    logic         clock;
    logic         rstn_in;
    logic         ah_cvalid;
    logic [7:0]   ah_ctag;
    logic [12:0]  ah_com;
    logic [63:0]  ah_cea;
    logic [11:0]  ah_csize;
    logic [7:0]   ha_croom;
    logic         ha_brvalid;
    logic [7:0]   ha_brtag;
    logic [5:0]   ha_brad;
    logic [511:0] ah_brdata;
    logic         ha_bwvalid;
    logic [7:0]   ha_bwtag;
    logic [5:0]   ha_bwad;
    logic [511:0] ha_bwdata;
    logic         ha_rvalid;
    logic [7:0]   ha_rtag;
    logic [7:0]   ha_response;
    logic [8:0]   ha_rcredits;
    logic         cmd_overflow;

    psl_command_responder dut (
        .clock(clock), .rstn_in(rstn_in),
        .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_com(ah_com),
        .ah_cea(ah_cea), .ah_csize(ah_csize), .ha_croom(ha_croom),
        .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brad(ha_brad),
        .ah_brdata(ah_brdata),
        .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwad(ha_bwad),
        .ha_bwdata(ha_bwdata),
        .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_response(ha_response),
        .ha_rcredits(ha_rcredits), .cmd_overflow(cmd_overflow)
    );

    typedef struct {
        logic [7:0] tag;
        logic [7:0] code;
        logic [8:0] credits;
        int         cyc;
    } resp_t;

    typedef struct {
        logic [5:0]   ad;
        logic [511:0] data;
    } bw_t;

    resp_t        rq[$];
    bw_t          bwq[$];
    logic [5:0]   brq[$];
    int           cyc;
    int           checks;
    int           passes;
    logic [511:0] afu_h0, afu_h1;

    localparam logic [511:0] DATA_A = {16{32'hA5A5_0001}};
    localparam logic [511:0] DATA_B = {16{32'h5B5B_0002}};
    localparam logic [511:0] DATA_E = {16{32'hE0E0_0003}};
    localparam logic [511:0] DATA_F = {16{32'h0F0F_0004}};
    localparam logic [511:0] DATA_G = {16{32'h6666_0005}};
    localparam logic [511:0] DATA_H = {16{32'h7777_0006}};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // AFU side of the buffer-read port, one cycle of latency.
    always @(posedge clock)
        if (ha_brvalid) ah_brdata <= (ha_brad == 6'd0) ? afu_h0 : afu_h1;

    always @(negedge clock) begin
        if (ha_rvalid)  rq.push_back('{ha_rtag, ha_response, ha_rcredits, cyc});
        if (ha_bwvalid) bwq.push_back('{ha_bwad, ha_bwdata});
        if (ha_brvalid) brq.push_back(ha_brad);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic resp_t resp_at(input int idx);
        resp_t none;
        none = '{8'hFF, 8'hFF, 9'h1FF, -1};
        if (idx < rq.size()) return rq[idx];
        return none;
    endfunction

    function automatic bw_t bw_at(input int idx);
        bw_t none;
        none = '{6'h3F, '0};
        if (idx < bwq.size()) return bwq[idx];
        return none;
    endfunction

    function automatic logic [5:0] br_at(input int idx);
        if (idx < brq.size()) return brq[idx];
        return 6'h3F;
    endfunction

    task automatic clear_queues();
        rq.delete();
        bwq.delete();
        brq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [7:0] tag, input logic [12:0] com,
                            input logic [63:0] cea, input logic [11:0] csize,
                            output int push_cyc);
        ah_cvalid = 1'b1;
        ah_ctag   = tag;
        ah_com    = com;
        ah_cea    = cea;
        ah_csize  = csize;
        push_cyc  = cyc;
        @(negedge clock);
        ah_cvalid = 1'b0;
    endtask

    task automatic test_reset();
        rstn_in = 1'b0;
        idle(3);
        rstn_in = 1'b1;
        idle(1);
        checks++; if (ha_croom !== 8'd8) $display("[TB] FAIL reset_croom: got %0d expected 8", ha_croom); else passes++;
        checks++; if (ha_rvalid !== 1'b0) $display("[TB] FAIL reset_rvalid: got %b expected 0", ha_rvalid); else passes++;
        checks++; if (ha_bwvalid !== 1'b0) $display("[TB] FAIL reset_bwvalid: got %b expected 0", ha_bwvalid); else passes++;
        checks++; if (ha_brvalid !== 1'b0) $display("[TB] FAIL reset_brvalid: got %b expected 0", ha_brvalid); else passes++;
        checks++; if (cmd_overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", cmd_overflow); else passes++;
        checks++; if (ha_rcredits !== 9'd0) $display("[TB] FAIL reset_rcredits: got %0d expected 0", ha_rcredits); else passes++;
    endtask

    task automatic test_write();
        int    pc;
        resp_t r;
        clear_queues();
        afu_h0 = DATA_A;
        afu_h1 = DATA_B;
        send_cmd(8'h05, 13'h0D00, 64'h80, 12'd128, pc);
        idle(10);
        r = resp_at(0);
        checks++; if (brq.size() !== 2) $display("[TB] FAIL write_br_count: got %0d expected 2", brq.size()); else passes++;
        checks++; if (br_at(0) !== 6'd0) $display("[TB] FAIL write_brad0: got %0d expected 0", br_at(0)); else passes++;
        checks++; if (br_at(1) !== 6'd1) $display("[TB] FAIL write_brad1: got %0d expected 1", br_at(1)); else passes++;
        checks++; if (rq.size() !== 1) $display("[TB] FAIL write_resp_count: got %0d expected 1", rq.size()); else passes++;
        checks++; if (r.tag !== 8'h05) $display("[TB] FAIL write_rtag: got %h expected 05", r.tag); else passes++;
        checks++; if (r.code !== 8'h00) $display("[TB] FAIL write_code: got %h expected 00", r.code); else passes++;
        checks++; if (r.credits !== 9'd1) $display("[TB] FAIL write_rcredits: got %0d expected 1", r.credits); else passes++;
        checks++; if (r.cyc - pc !== 5) $display("[TB] FAIL write_latency: got %0d expected 5", r.cyc - pc); else passes++;
        checks++; if (bwq.size() !== 0) $display("[TB] FAIL write_no_bw: got %0d expected 0", bwq.size()); else passes++;
    endtask

    task automatic test_read(input logic [7:0] tag, input logic [63:0] cea,
                             input logic [511:0] exp0, input logic [511:0] exp1);
        int    pc;
        resp_t r;
        bw_t   w0, w1;
        clear_queues();
        send_cmd(tag, 13'h0A00, cea, 12'd128, pc);
        idle(10);
        r  = resp_at(0);
        w0 = bw_at(0);
        w1 = bw_at(1);
        checks++; if (bwq.size() !== 2) $display("[TB] FAIL read_bw_count: got %0d expected 2", bwq.size()); else passes++;
        checks++; if (w0.ad !== 6'd0) $display("[TB] FAIL read_bwad0: got %0d expected 0", w0.ad); else passes++;
        checks++; if (w0.data !== exp0) $display("[TB] FAIL read_data0: got %h expected %h", w0.data[31:0], exp0[31:0]); else passes++;
        checks++; if (w1.ad !== 6'd1) $display("[TB] FAIL read_bwad1: got %0d expected 1", w1.ad); else passes++;
        checks++; if (w1.data !== exp1) $display("[TB] FAIL read_data1: got %h expected %h", w1.data[31:0], exp1[31:0]); else passes++;
        checks++; if (r.tag !== tag) $display("[TB] FAIL read_rtag: got %h expected %h", r.tag, tag); else passes++;
        checks++; if (r.code !== 8'h00) $display("[TB] FAIL read_code: got %h expected 00", r.code); else passes++;
        checks++; if (r.cyc - pc !== 5) $display("[TB] FAIL read_latency: got %0d expected 5", r.cyc - pc); else passes++;
        checks++; if (brq.size() !== 0) $display("[TB] FAIL read_no_br: got %0d expected 0", brq.size()); else passes++;
    endtask

    task automatic test_errors();
        logic [7:0]  tags  [6] = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        logic [12:0] coms  [6] = '{13'h0A00, 13'h1F00, 13'h0D60, 13'h0A50, 13'h0001, 13'h0D00};
        logic [63:0] ceas  [6] = '{64'h8000, 64'h80, 64'h80, 64'h80, 64'h0, 64'h1_0000_0000};
        logic [11:0] sizes [6] = '{12'd128, 12'd128, 12'd0, 12'd129, 12'd0, 12'd128};
        logic [7:0]  codes [6] = '{8'h01, 8'h08, 8'h01, 8'h01, 8'h00, 8'h01};
        int    pc;
        resp_t r;
        for (int i = 0; i < 6; i++) begin
            clear_queues();
            send_cmd(tags[i], coms[i], ceas[i], sizes[i], pc);
            idle(6);
            r = resp_at(0);
            checks++; if (rq.size() !== 1) $display("[TB] FAIL err%0d_resp_count: got %0d expected 1", i, rq.size()); else passes++;
            checks++; if (r.tag !== tags[i]) $display("[TB] FAIL err%0d_rtag: got %h expected %h", i, r.tag, tags[i]); else passes++;
            checks++; if (r.code !== codes[i]) $display("[TB] FAIL err%0d_code: got %h expected %h", i, r.code, codes[i]); else passes++;
            checks++; if (r.cyc - pc !== 3) $display("[TB] FAIL err%0d_latency: got %0d expected 3", i, r.cyc - pc); else passes++;
            checks++; if (bwq.size() + brq.size() !== 0) $display("[TB] FAIL err%0d_no_data: got %0d buffer beats expected 0", i, bwq.size() + brq.size()); else passes++;
        end
    endtask

    // Thirteen restarts on consecutive cycles: pops every third cycle let the
    // FIFO reach eight entries after the twelfth push, so the last one drops.
    task automatic test_back_to_back();
        resp_t r;
        clear_queues();
        for (int i = 0; i < 13; i++) begin
            ah_cvalid = 1'b1;
            ah_ctag   = 8'h20 + 8'(i);
            ah_com    = 13'h0001;
            ah_cea    = 64'h0;
            ah_csize  = 12'd0;
            @(negedge clock);
        end
        ah_cvalid = 1'b0;
        idle(60);
        checks++; if (cmd_overflow !== 1'b1) $display("[TB] FAIL b2b_overflow: got %b expected 1", cmd_overflow); else passes++;
        checks++; if (rq.size() !== 12) $display("[TB] FAIL b2b_resp_count: got %0d expected 12", rq.size()); else passes++;
        for (int i = 0; i < 12; i++) begin
            r = resp_at(i);
            checks++; if (r.tag !== 8'h20 + 8'(i)) $display("[TB] FAIL b2b_tag%0d: got %h expected %h", i, r.tag, 8'h20 + 8'(i)); else passes++;
        end
    endtask

    task automatic test_reset_mid_write();
        int    pc;
        bit    seen;
        resp_t r;
        clear_queues();
        afu_h0 = DATA_E;
        afu_h1 = DATA_F;
        send_cmd(8'h30, 13'h0D00, 64'h100, 12'd128, pc);
        idle(8);
        r = resp_at(0);
        checks++; if (r.tag !== 8'h30) $display("[TB] FAIL mid_first_write_tag: got %h expected 30", r.tag); else passes++;

        clear_queues();
        afu_h0 = DATA_G;
        afu_h1 = DATA_H;
        send_cmd(8'h31, 13'h0D60, 64'h100, 12'd128, pc);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ha_brvalid && ha_brad == 6'd1) seen = 1'b1;
            else @(negedge clock);
        end
        checks++; if (seen !== 1'b1) $display("[TB] FAIL mid_br1_seen: got %b expected 1", seen); else passes++;
        rstn_in = 1'b0;
        @(negedge clock);
        rstn_in = 1'b1;
        rq.delete();
        idle(10);
        checks++; if (rq.size() !== 0) $display("[TB] FAIL mid_no_resp: got %0d expected 0", rq.size()); else passes++;
        checks++; if (cmd_overflow !== 1'b0) $display("[TB] FAIL mid_overflow_cleared: got %b expected 0", cmd_overflow); else passes++;
        checks++; if (ha_croom !== 8'd8) $display("[TB] FAIL mid_croom: got %0d expected 8", ha_croom); else passes++;
        test_read(8'h32, 64'h100, DATA_E, DATA_F);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        cyc       = 0;
        rstn_in   = 1'b0;
        ah_cvalid = 1'b0;
        ah_ctag   = 8'h00;
        ah_com    = 13'h0;
        ah_cea    = 64'h0;
        ah_csize  = 12'd0;
        ah_brdata = '0;
        afu_h0    = '0;
        afu_h1    = '0;
        $display("[TB] starting psl_command_responder bench");
        test_reset();
        test_write();
        test_read(8'h06, 64'h80, DATA_A, DATA_B);
        test_read(8'h0D, 64'hC5, DATA_A, DATA_B);
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
